// File: rtl/multiplicador_recomp_7bits_if.sv
// Request/result bundle for the 7-bit Q*B+R recomposer.
// master drives the operands and start; slave is the recomposer itself.
interface multiplicador_recomp_7bits_if;
  logic        start;
  logic [6:0]  Q_in;
  logic [6:0]  B_in;
  logic [6:0]  R_in;
  logic [13:0] P;
  logic        consistent;
  logic        busy;
  logic        done;

  modport master (
    output start, Q_in, B_in, R_in,
    input  P, consistent, busy, done
  );

  modport slave (
    input  start, Q_in, B_in, R_in,
    output P, consistent, busy, done
  );
endinterface

// File: rtl/multiplicador_recomp_7bits.sv
// Sequential shift-add recomposer: P = Q*B + R over seven cycles.
// It also flags whether (Q, B, R) forms a consistent 7-bit division.
module multiplicador_recomp_7bits (
  input  logic                               clk,
  input  logic                               rst,
  multiplicador_recomp_7bits_if.slave        bus
);

  localparam int unsigned W_OP   = 7;
  localparam int unsigned W_P    = 14;
  localparam int unsigned W_I    = 3;
  localparam int unsigned I_LAST = 6;
  localparam int unsigned P_MAX  = 127;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [W_P-1:0]  acc_q,   acc_d;
  logic [W_I-1:0]  i_q,     i_d;
  logic [W_OP-1:0] q_q,     q_d;
  logic [W_OP-1:0] b_q,     b_d;
  logic [W_OP-1:0] r_q,     r_d;
  logic [W_P-1:0]  p_q,     p_d;
  logic            cons_q,  cons_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;

  logic [W_P-1:0]  acc_step;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      i_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
      cons_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      q_q     <= q_d;
      b_q     <= b_d;
      r_q     <= r_d;
      p_q     <= p_d;
      cons_q  <= cons_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // One partial product per cycle; max sum 16256 fits in 14 bits, no carry-out
  always_comb begin
    acc_step = acc_q;
    if (q_q[i_q]) begin
      acc_step = acc_q + (W_P'(b_q) << i_q);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    i_d     = i_q;
    q_d     = q_q;
    b_d     = b_q;
    r_d     = r_q;
    p_d     = p_q;
    cons_d  = cons_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (bus.start) begin
          q_d     = bus.Q_in;
          b_d     = bus.B_in;
          r_d     = bus.R_in;
          acc_d   = W_P'(bus.R_in);
          i_d     = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        acc_d = acc_step;
        i_d   = i_q + W_I'(1);
        if (i_q == W_I'(I_LAST)) begin
          // P and consistent only move here so they hold across the next run
          p_d     = acc_step;
          cons_d  = (b_q != '0) && (r_q < b_q) && (acc_step <= W_P'(P_MAX));
          i_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        i_d     = '0;
      end
    endcase
  end

  assign bus.P          = p_q;
  assign bus.consistent = cons_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_multiplicador_recomp_7bits.sv
// Bench for multiplicador_recomp_7bits: directed vector table, random ops
// against an arithmetic model, and multi-cycle handshake/reset sequences.
module tb_multiplicador_recomp_7bits;

  logic clk;
  logic rst_n;

  multiplicador_recomp_7bits_if bus ();

  multiplicador_recomp_7bits dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int q;
    int b;
    int r;
    int p;
    int c;
  } vec_t;

  int n_cmp;
  int n_fail;
  int last_p;
  int last_c;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int model_p(input int q, input int b, input int r);
    return q * b + r;
  endfunction

  function automatic int model_c(input int q, input int b, input int r);
    int p;
    p = q * b + r;
    return ((b != 0) && (r < b) && (p <= 127)) ? 1 : 0;
  endfunction

  task automatic drive_ops(input int q, input int b, input int r);
    bus.Q_in = 7'(q);
    bus.B_in = 7'(b);
    bus.R_in = 7'(r);
  endtask

  // Waits (bounded) for done, returns the number of edges after the accept edge
  task automatic wait_done(output int k);
    k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Single operation from IDLE/FIN: start pulse, then check latency/result
  task automatic do_op(input string name, input int q, input int b, input int r,
                       input int exp_p, input int exp_c);
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    drive_ops(q, b, r);
    @(negedge clk);
    bus.start = 1'b0;
    drive_ops($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
    check({name, ".busy_acc"}, int'(bus.busy), 1);
    check({name, ".done_acc"}, int'(bus.done), 0);
    check({name, ".P_hold"}, int'(bus.P), last_p);
    wait_done(k);
    check({name, ".lat"}, k, 7);
    check({name, ".busy_fin"}, int'(bus.busy), 0);
    check({name, ".P"}, int'(bus.P), exp_p);
    check({name, ".cons"}, int'(bus.consistent), exp_c);
    last_p = exp_p;
    last_c = exp_c;
  endtask

  vec_t vecs[8];

  initial begin
    int k;
    n_cmp  = 0;
    n_fail = 0;
    last_p = 0;
    last_c = 0;

    vecs[0] = '{q: 3,   b: 2,   r: 1,   p: 7,     c: 1};
    vecs[1] = '{q: 7,   b: 7,   r: 1,   p: 50,    c: 1};
    vecs[2] = '{q: 19,  b: 5,   r: 4,   p: 99,    c: 1};
    vecs[3] = '{q: 12,  b: 10,  r: 0,   p: 120,   c: 1};
    vecs[4] = '{q: 127, b: 127, r: 127, p: 16256, c: 0};
    vecs[5] = '{q: 0,   b: 9,   r: 5,   p: 5,     c: 1};
    vecs[6] = '{q: 5,   b: 0,   r: 3,   p: 3,     c: 0};
    vecs[7] = '{q: 10,  b: 5,   r: 7,   p: 57,    c: 0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    drive_ops(0, 0, 0);
    #12;
    check("rst.P", int'(bus.P), 0);
    check("rst.cons", int'(bus.consistent), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.busy", int'(bus.busy), 0);
    check("idle.done", int'(bus.done), 0);

    // Directed table
    foreach (vecs[j]) begin
      do_op($sformatf("vec%0d", j), vecs[j].q, vecs[j].b, vecs[j].r, vecs[j].p, vecs[j].c);
    end

    // Random operations against the arithmetic model
    for (int j = 0; j < 30; j++) begin
      int q, b, r;
      q = int'($urandom_range(0, 127));
      b = (j % 7 == 0) ? 0 : int'($urandom_range(0, 127));
      r = (j % 3 == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 127));
      if (j % 4 == 0) q = int'($urandom_range(0, 10));
      do_op($sformatf("rnd%0d", j), q, b, r, model_p(q, b, r), model_c(q, b, r));
    end

    // Start pulse in the middle of MUL is ignored
    @(negedge clk);
    bus.start = 1'b1;
    drive_ops(3, 2, 1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    drive_ops(100, 1, 0);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_start.busy", int'(bus.busy), 1);
    k = 4;
    while (bus.done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("busy_start.lat", k, 7);
    check("busy_start.P", int'(bus.P), 7);
    check("busy_start.cons", int'(bus.consistent), 1);
    repeat (9) @(negedge clk);
    check("busy_start.stay_done", int'(bus.done), 1);
    check("busy_start.stay_busy", int'(bus.busy), 0);
    check("busy_start.stay_P", int'(bus.P), 7);
    last_p = 7;

    // Back-to-back with start held high
    begin
      int bq[4] = '{19, 7, 0, 127};
      int bb[4] = '{5, 7, 0, 1};
      int br[4] = '{4, 1, 6, 0};
      @(negedge clk);
      bus.start = 1'b1;
      drive_ops(bq[0], bb[0], br[0]);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check($sformatf("b2b%0d.done_drop", j), int'(bus.done), 0);
        check($sformatf("b2b%0d.busy", j), int'(bus.busy), 1);
        check($sformatf("b2b%0d.P_hold", j), int'(bus.P), last_p);
        wait_done(k);
        check($sformatf("b2b%0d.lat", j), k, 7);
        check($sformatf("b2b%0d.P", j), int'(bus.P), model_p(bq[j], bb[j], br[j]));
        check($sformatf("b2b%0d.cons", j), int'(bus.consistent),
              model_c(bq[j], bb[j], br[j]));
        last_p = model_p(bq[j], bb[j], br[j]);
        if (j < 3) drive_ops(bq[j+1], bb[j+1], br[j+1]);
        else       bus.start = 1'b0;
      end
      @(negedge clk);
      check("b2b.final_done", int'(bus.done), 1);
    end

    // Asynchronous reset in the middle of MUL
    @(negedge clk);
    bus.start = 1'b1;
    drive_ops(7, 7, 1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst.P", int'(bus.P), 0);
    check("mid_rst.cons", int'(bus.consistent), 0);
    check("mid_rst.busy", int'(bus.busy), 0);
    check("mid_rst.done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.busy", int'(bus.busy), 0);
    last_p = 0;
    do_op("post_rst", 19, 5, 4, 99, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
